// File: rtl/implicit_reg_executor_if.sv
// implicit_reg_executor_if: request, stack-memory and register-view signals of the implicit-register executor
interface implicit_reg_executor_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic                req_valid;
  logic                req_ready;
  logic                set_reg_address;
  logic [ADDR_W-1:0]   reg_address;
  logic [1:0]          op;
  logic [DATA_W/2-1:0] imm;
  logic                mem_req;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_addr;
  logic                mem_ack;
  logic                done;
  logic                err;
  logic [DATA_W-1:0]   radr;
  logic [DATA_W-1:0]   rli;
  logic [DATA_W-1:0]   sp;
  modport master (
    output req_valid, set_reg_address, reg_address, op, imm, mem_ack,
    input  req_ready, mem_req, mem_we, mem_addr, done, err, radr, rli, sp
  );
  modport slave (
    input  req_valid, set_reg_address, reg_address, op, imm, mem_ack,
    output req_ready, mem_req, mem_we, mem_addr, done, err, radr, rli, sp
  );
endinterface

// File: rtl/implicit_reg_executor.sv
// implicit_reg_executor: executes SETADDL/H, LDIL/H and PUSH/POP on RADR, RLI and SP.
// Defining STACK_GUARD_EN rejects PUSH at SP_LIMIT and POP at SP_RESET.
module implicit_reg_executor #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 4,
  parameter logic [ADDR_W-1:0]  RADR_IDX = 4'd13,
  parameter logic [ADDR_W-1:0]  RLI_IDX  = 4'd14,
  parameter logic [ADDR_W-1:0]  SP_IDX   = 4'd15,
  parameter logic [DATA_W-1:0]  SP_RESET = 16'hFFFF,
  parameter logic [DATA_W-1:0]  SP_LIMIT = 16'hFF00
) (
  input  logic clk,
  input  logic rst_n,
  implicit_reg_executor_if.slave bus
);
  localparam int H = DATA_W / 2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MEM  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};
`ifdef STACK_GUARD_EN
  localparam logic GUARD_EN = 1'b1;
`else
  localparam logic GUARD_EN = 1'b0;
`endif

  logic [1:0]        r_state;
  logic              r_ready;
  logic              r_set;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_op;
  logic [H-1:0]      r_imm;
  logic              r_err;
  logic [DATA_W-1:0] r_radr;
  logic [DATA_W-1:0] r_rli;
  logic [DATA_W-1:0] r_sp;

  logic              w_hs;
  logic              w_hit;
  logic              w_guard;
  logic              w_go_mem;
  logic              w_bad;
  logic              w_wr;
  logic [1:0]        w_next;
  logic [DATA_W-1:0] w_cur;
  logic [DATA_W-1:0] w_half;
  logic [DATA_W-1:0] w_spm1;
  logic [DATA_W-1:0] w_spp1;

  always_comb begin
    w_hs     = bus.req_valid & r_ready;
    w_hit    = (r_addr == RADR_IDX) | (r_addr == RLI_IDX) | (r_addr == SP_IDX);
    w_guard  = GUARD_EN & (r_op[0] ? (r_sp == SP_RESET) : (r_sp == SP_LIMIT));
    w_go_mem = r_set & r_op[1] & (r_addr == SP_IDX) & ~w_guard;
    w_bad    = r_set & (r_op[1] ? ((r_addr != SP_IDX) | w_guard) : ~w_hit);
    w_wr     = (r_state == EXEC) & r_set & ~r_op[1] & w_hit;
    w_cur    = (r_addr == RADR_IDX) ? r_radr : (r_addr == RLI_IDX) ? r_rli : r_sp;
    w_half   = r_op[0] ? {r_imm, w_cur[H-1:0]} : {w_cur[DATA_W-1:H], r_imm};
    w_spm1   = r_sp - ONE;
    w_spp1   = r_sp + ONE;
    w_next   = (r_state == IDLE) ? (w_hs ? EXEC : IDLE) :
               (r_state == EXEC) ? (w_go_mem ? MEM : DONE) :
               (r_state == MEM)  ? (bus.mem_ack ? DONE : MEM) : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_set   <= 1'b0;
      r_addr  <= '0;
      r_op    <= '0;
      r_imm   <= '0;
      r_err   <= 1'b0;
      r_radr  <= '0;
      r_rli   <= '0;
      r_sp    <= SP_RESET;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
      if (r_state == IDLE && w_hs) begin
        r_set  <= bus.set_reg_address;
        r_addr <= bus.reg_address;
        r_op   <= bus.op;
        r_imm  <= bus.imm;
      end
      if (r_state == EXEC) r_err <= w_bad;
      if (w_wr && r_addr == RADR_IDX) r_radr <= w_half;
      if (w_wr && r_addr == RLI_IDX) r_rli <= w_half;
      // SP moves only when the memory accepts the access, so an aborted PUSH/POP leaves it intact
      if (w_wr && r_addr == SP_IDX) r_sp <= w_half;
      else if (r_state == MEM && bus.mem_ack) r_sp <= r_op[0] ? w_spp1 : w_spm1;
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.mem_req   = (r_state == MEM);
  assign bus.mem_we    = (r_state == MEM) & ~r_op[0];
  assign bus.mem_addr  = (r_state == MEM) ? (r_op[0] ? r_sp : w_spm1) : '0;
  assign bus.done      = (r_state == DONE);
  assign bus.err       = (r_state == DONE) & r_err;
  assign bus.radr      = r_radr;
  assign bus.rli       = r_rli;
  assign bus.sp        = r_sp;
endmodule

// File: tb/tb_implicit_reg_executor.sv
// tb_implicit_reg_executor: directed and random requests checked against a register/stack reference model
module tb_implicit_reg_executor;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk;
  logic rst_n;
  int total;
  int bad;
  logic [15:0] m_radr;
  logic [15:0] m_rli;
  logic [15:0] m_sp;

  implicit_reg_executor_if bus ();
  implicit_reg_executor dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_radr = 16'h0000;
    m_rli  = 16'h0000;
    m_sp   = 16'hFFFF;
  endtask

  task automatic run_req(input logic s, input logic [3:0] a, input logic [1:0] o,
                         input logic [7:0] im, input int wt);
    logic        mem;
    logic        e;
    logic [15:0] ea;
    logic [15:0] cur;
    logic [15:0] nr;
    logic [15:0] nl;
    logic [15:0] ns;
    int          n;
    mem = 1'b0;
    e   = 1'b0;
    ea  = 16'h0;
    nr  = m_radr;
    nl  = m_rli;
    ns  = m_sp;
    if (s) begin
      if (o < 2) begin
        if (a == 13 || a == 14 || a == 15) begin
          cur = (a == 13) ? m_radr : (a == 14) ? m_rli : m_sp;
          cur = o[0] ? {im, cur[7:0]} : {cur[15:8], im};
          if (a == 13) nr = cur;
          else if (a == 14) nl = cur;
          else ns = cur;
        end else e = 1'b1;
      end else if (a == 15 && !(GUARD && (o == 2'd3 ? m_sp == 16'hFFFF : m_sp == 16'hFF00))) begin
        mem = 1'b1;
        ea  = (o == 2'd2) ? m_sp - 16'd1 : m_sp;
        ns  = (o == 2'd2) ? m_sp - 16'd1 : m_sp + 16'd1;
      end else e = 1'b1;
    end
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.set_reg_address = s;
    bus.reg_address = a;
    bus.op = o;
    bus.imm = im;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.set_reg_address = 1'($urandom);
    bus.reg_address = 4'($urandom);
    bus.op = 2'($urandom);
    bus.imm = 8'($urandom);
    bus.mem_ack = 1'($urandom);
    chk("exec_done", bus.done, 0);
    chk("exec_mreq", bus.mem_req, 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    if (!mem) begin
      chk("done", bus.done, 1);
      chk("err", bus.err, e);
      chk("nomem", bus.mem_req, 0);
    end else begin
      for (int i = 0; i <= wt; i++) begin
        chk("mreq", bus.mem_req, 1);
        chk("mwe", bus.mem_we, o == 2'd2);
        chk("maddr", bus.mem_addr, ea);
        chk("mem_nodone", bus.done, 0);
        if (i == wt) bus.mem_ack = 1'b1;
        @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      chk("mdone", bus.done, 1);
      chk("merr", bus.err, 0);
      chk("mreq_off", bus.mem_req, 0);
    end
    chk("radr", bus.radr, nr);
    chk("rli", bus.rli, nl);
    chk("sp", bus.sp, ns);
    m_radr = nr;
    m_rli  = nl;
    m_sp   = ns;
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("err_pulse", bus.err, 0);
  endtask

  initial begin
    logic [3:0] a;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.set_reg_address = 1'b0;
    bus.reg_address = 4'd0;
    bus.op = 2'd0;
    bus.imm = 8'd0;
    bus.mem_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_radr", bus.radr, 16'h0000);
    chk("rst_rli", bus.rli, 16'h0000);
    chk("rst_sp", bus.sp, 16'hFFFF);
    chk("rst_done", bus.done, 0);
    chk("rst_mreq", bus.mem_req, 0);
    chk("rst_maddr", bus.mem_addr, 16'h0000);
    chk("rst_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.req_ready, 1);
    run_req(1'b1, 4'd13, 2'd0, 8'h34, 0);
    run_req(1'b1, 4'd13, 2'd1, 8'h12, 0);
    chk("radr_1234", bus.radr, 16'h1234);
    run_req(1'b1, 4'd15, 2'd2, 8'h00, 3);
    chk("sp_fffe", bus.sp, 16'hFFFE);
    run_req(1'b1, 4'd15, 2'd3, 8'h00, 1);
    chk("sp_ffff", bus.sp, 16'hFFFF);
    run_req(1'b1, 4'd14, 2'd2, 8'h00, 0);
    run_req(1'b1, 4'd3, 2'd0, 8'hAA, 0);
    run_req(1'b0, 4'd13, 2'd0, 8'h55, 0);
    run_req(1'b1, 4'd15, 2'd3, 8'h00, 0);
    if (!GUARD) begin
      chk("pop_wrap", bus.sp, 16'h0000);
      run_req(1'b1, 4'd15, 2'd2, 8'h00, 2);
      chk("push_wrap", bus.sp, 16'hFFFF);
    end
    // abort a PUSH while waiting on memory
    bus.req_valid = 1'b1;
    bus.set_reg_address = 1'b1;
    bus.reg_address = 4'd15;
    bus.op = 2'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_inmem", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_mreq", bus.mem_req, 0);
    chk("abort_sp", bus.sp, 16'hFFFF);
    chk("abort_done", bus.done, 0);
    repeat (2) @(negedge clk);
    chk("abort_nodone", bus.done, 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 80; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(13 + $urandom_range(0, 2));
      run_req(($urandom_range(0, 7) != 0), a, 2'($urandom), 8'($urandom), $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
